sd_spi_card_responder: RTL and testbench
========================================

Name: sd_spi_card_responder

Overview:
- Synthesizable SPI-mode SD card responder: the card end of the SD SPI command protocol.
- Samples the host's spi_clk/cs/mosi, parses 48-bit command frames and drives R1/R3/R7 responses on miso.
- Used as an on-FPGA card model so the host controller's init sequence (no-ops, CMD0, CMD8, CMD55/ACMD41, CMD58) can be run and checked without a physical card.
- No data-block transfers.

Parameters:
- NCR, 1, number of 0xFF filler bytes between the command's last byte and the first response byte (legal 1..8).
- INIT_POLLS, 2, number of ACMD41 commands answered "still idle" (R1=0x01) before the card answers ready (0x00).
- HIGH_CAPACITY, 1, value of the OCR CCS bit (OCR bit 30).
- MIN_INIT_CLKS, 74, spi_clk rising edges with cs high required before CMD0 is honoured.

Ports:
- clk  in  1  system clock; must run at ≥4× spi_clk.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  host SPI clock, mode 0.
- cs  in  1  active-low chip select.
- mosi  in  1  host→card data, MSB first.
- miso  out  1  card→host data, MSB first.
- in_spi_mode  out  1  set once CMD0 has been accepted.
- card_ready  out  1  in_spi_mode && idle cleared by ACMD41.
- cmd_valid  out  1  one-clk pulse when a complete frame is decoded.
- cmd_index  out  6  index of the last decoded frame.
- cmd_arg  out  32  argument of the last decoded frame.

Behaviour:
- Reset values:
  - miso=1, in_spi_mode=0, card_ready=0, cmd_valid=0, cmd_index=0, cmd_arg=0.
  - idle=1, app_cmd=0, polls_left=INIT_POLLS, init_clk_cnt=0, state=WAIT_CMD.
- Reset asserted mid-transfer aborts everything immediately.
- Input sync: spi_clk, cs, mosi each pass through 2-flop synchronisers. Edge detect on synced spi_clk.
- On a rising edge with cs low: shift mosi into the rx byte.
- On a falling edge with cs low: advance the tx shifter; miso takes the next bit.
- Bit counter clears while cs is high, so bytes align to the cs falling edge.
- init_clk_cnt counts rising edges with cs high and saturates at MIN_INIT_CLKS.
- cs high:
  - miso=1; the state returns to WAIT_CMD; any partial frame or response is discarded.
  - Flags (idle, app_cmd, polls_left, in_spi_mode) are retained.
- States:
  - WAIT_CMD: tx byte 0xFF. A received byte with bits[7:6]=01 → RX_CMD, byte_cnt=1. Other bytes are ignored.
  - RX_CMD: collect 5 more bytes (arg[31:0], then crc byte). After byte 6: decode, pulse cmd_valid, load the response buffer → NCR.
  - NCR: send NCR bytes of 0xFF → TX_RESP.
  - TX_RESP: send 1 (R1) or 5 (R3/R7) bytes → WAIT_CMD (0xFF thereafter).
  - A new frame start received during NCR/TX_RESP is ignored; the host must clock out the response first.
- Decode:
  - R1 = {0, 0, 0, 0, crc_err, illegal, 0, idle}.
  - CRC7 (poly x^7+x^3+1) is computed over bytes 1..5. crc_err is set if frame byte 6 ≠ {crc7, 1}. The CRC is checked only for CMD0 and CMD8.
  - Before in_spi_mode: only CMD0 is acted on, and only if init_clk_cnt==MIN_INIT_CLKS. Any other frame gets no response (the FSM still runs NCR/TX_RESP, but all bytes are 0xFF).
  - CMD0: good CRC → in_spi_mode=1, idle=1, polls_left=INIT_POLLS, app_cmd=0, R1. Bad CRC → R1 with crc_err, no state change.
  - CMD8 → R7: R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0]. Bad CRC → R1 only.
  - CMD55 → app_cmd=1, R1.
  - CMD41 with app_cmd=1:
    - polls_left>0 → decrement, R1 (idle=1).
    - polls_left==0 → idle=0, R1=0x00.
  - CMD41 without app_cmd → R1 with illegal.
  - CMD58 → R3: R1, then OCR = {~idle, HIGH_CAPACITY, 6'b0, 24'hFF8000}, MSB first.
  - Any other index → R1 with illegal.
  - app_cmd clears after any command other than CMD55.
- R1 reflects the idle value after the command's effect (ACMD41 ready → 0x00).
- Latency: first response bit appears on the falling spi_clk edge ending byte NCR+6, plus ≤3 clk of sync delay.

Decomposition:
- Package sd_spi_pkg holds:
  - CMD0/8/55/41/58 index constants.
  - R1 bit positions.
  - OCR voltage-window constant.
  - Response-length constants.
  - State localparams.
- Sub-module sd_crc7: serial CRC7, one bit per enable, with clear.

Test Plan:
- 80 spi_clk with cs high, then cs low, frame 40 00 00 00 00 95, then clock 0xFF bytes → miso returns FF, 01; in_spi_mode=1; cmd_valid pulses once with cmd_index=0.
- Only 40 clocks with cs high, then CMD0 → all bytes FF; in_spi_mode stays 0. Repeat after 80 clocks → 01.
- After CMD0, send 48 00 00 01 AA 87 → 01 00 00 01 AA. Same frame with crc byte 01 → 09 only.
- INIT_POLLS=2, loop CMD55 (77 00 00 00 00 01) + ACMD41 (69 40 00 00 00 01) → ACMD41 answers 01, 01, 00; card_ready=1. Then CMD58 (7A …) → 00 C0 FF 80 00.
- CMD17 (51 …) → 05 while idle. CMD41 without a preceding CMD55 → 05.
- Raise cs after 3 command bytes → no response; miso=1. Next full CMD0 → 01. Assert rst_n low mid-response → miso=1 and in_spi_mode=0 immediately.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared constants, types and helpers for the SPI-mode SD card responder.
// Holds command indices, R1 bit positions, OCR fields, response lengths,
// the frame FSM state type and the serial CRC7 step function.
package sd_spi_pkg;

    // Command indices the responder understands
    localparam logic [5:0] CMD_GO_IDLE       = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND  = 6'd8;
    localparam logic [5:0] ACMD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD       = 6'd55;
    localparam logic [5:0] CMD_READ_OCR      = 6'd58;

    // R1 status bit positions
    localparam int unsigned R1_IDLE_BIT    = 0;
    localparam int unsigned R1_ILLEGAL_BIT = 2;
    localparam int unsigned R1_CRC_ERR_BIT = 3;

    // OCR voltage window (2.7-3.6 V)
    localparam logic [23:0] OCR_VOLT_WINDOW = 24'hFF8000;

    // Response lengths in bytes
    localparam int unsigned RESP_LEN_R1    = 1;
    localparam int unsigned RESP_LEN_R3R7  = 5;
    localparam int unsigned RESP_BYTES_MAX = 5;

    // Command frame geometry and idle line value
    localparam int unsigned FRAME_BYTES = 6;
    localparam logic [7:0]  FILL_BYTE   = 8'hFF;

    // CRC7 polynomial x^7 + x^3 + 1 (implicit x^7)
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        ST_WAIT_CMD = 2'd0,
        ST_RX_CMD   = 2'd1,
        ST_NCR      = 2'd2,
        ST_TX_RESP  = 2'd3
    } state_t;

    // Decoded command fields of the frame being received
    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
    } cmd_fields_t;

    // One serial CRC7 step, MSB-first data
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per enable.
// Ports: clk, rst_n; clr restarts the CRC (combined with en, the bit is
// folded into a fresh CRC); en shifts din in; crc is the running value.
module sd_crc7
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_step(clr ? 7'h00 : crc, din);
        end else if (clr) begin
            crc <= 7'h00;
        end
    end

endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: parses 48-bit command frames from the host
// and answers with R1/R3/R7 responses, modelling the card init sequence.
// Ports:
//   clk, rst_n          system clock (>= 4x spi_clk), async active-low reset
//   spi_clk, cs, mosi   host SPI signals (mode 0, cs active low)
//   miso                card data out, MSB first, 1 while deselected
//   in_spi_mode         CMD0 accepted
//   card_ready          in SPI mode and no longer idle
//   cmd_valid           one-clk pulse per decoded frame
//   cmd_index, cmd_arg  fields of the last decoded frame
module sd_spi_card_responder
    import sd_spi_pkg::*;
#(
    parameter int unsigned NCR           = 1,
    parameter int unsigned INIT_POLLS    = 2,
    parameter int unsigned HIGH_CAPACITY = 1,
    parameter int unsigned MIN_INIT_CLKS = 74
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        in_spi_mode,
    output logic        card_ready,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg
);

    localparam int unsigned INIT_W = (MIN_INIT_CLKS < 1) ? 1 : $clog2(MIN_INIT_CLKS + 1);
    localparam int unsigned POLL_W = (INIT_POLLS < 1) ? 1 : $clog2(INIT_POLLS + 1);
    localparam int unsigned RESP_W = 8 * RESP_BYTES_MAX;

    localparam logic [2:0] NCR_LAST  = 3'(NCR - 1);
    localparam logic [2:0] ARG_LAST  = 3'(FRAME_BYTES - 2);
    localparam logic [2:0] CRC_BYTE  = 3'(FRAME_BYTES - 1);
    localparam logic [2:0] LAST_R1   = 3'(RESP_LEN_R1 - 1);
    localparam logic [2:0] LAST_R3R7 = 3'(RESP_LEN_R3R7 - 1);

    // Input synchronisers and edge detect
    logic [1:0] sck_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sck_d;
    logic       sck_s;
    logic       cs_act;
    logic       mosi_s;
    logic       rise;
    logic       fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
            sck_d     <= sck_sync[1];
        end
    end

    assign sck_s  = sck_sync[1];
    assign cs_act = ~cs_sync[1];
    assign mosi_s = mosi_sync[1];
    assign rise   = sck_s & ~sck_d;
    assign fall   = ~sck_s & sck_d;

    // Receive shifter; bit counter aligns bytes to the cs falling edge
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte_c;
    logic       byte_done_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'h00;
        end else if (!cs_act) begin
            bit_cnt  <= 3'd0;
        end else if (rise) begin
            bit_cnt  <= 3'(bit_cnt + 3'd1);
            rx_shift <= {rx_shift[5:0], mosi_s};
        end
    end

    assign rx_byte_c   = {rx_shift, mosi_s};
    assign byte_done_c = cs_act & rise & (bit_cnt == 3'd7);

    // Power-up clock counter, saturating
    logic [INIT_W-1:0] init_clk_cnt;
    logic              init_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_clk_cnt <= '0;
        end else if (!cs_act && rise && !init_done) begin
            init_clk_cnt <= INIT_W'(init_clk_cnt + 1'b1);
        end
    end

    assign init_done = (init_clk_cnt == INIT_W'(MIN_INIT_CLKS));

    // Frame FSM: state register
    state_t     state;
    state_t     state_nxt;
    logic [2:0] byte_cnt;
    logic [2:0] byte_cnt_nxt;
    logic       frame_done_c;
    logic [2:0] resp_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT_CMD;
            byte_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Frame FSM: next state, advancing once per completed byte
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        frame_done_c = 1'b0;
        if (!cs_act) begin
            state_nxt    = ST_WAIT_CMD;
            byte_cnt_nxt = 3'd0;
        end else if (byte_done_c) begin
            case (state)
                ST_WAIT_CMD: begin
                    if (rx_byte_c[7:6] == 2'b01) begin
                        state_nxt    = ST_RX_CMD;
                        byte_cnt_nxt = 3'd1;
                    end
                end
                ST_RX_CMD: begin
                    if (byte_cnt == CRC_BYTE) begin
                        state_nxt    = ST_NCR;
                        byte_cnt_nxt = 3'd0;
                        frame_done_c = 1'b1;
                    end else begin
                        byte_cnt_nxt = 3'(byte_cnt + 3'd1);
                    end
                end
                ST_NCR: begin
                    if (byte_cnt == NCR_LAST) begin
                        state_nxt    = ST_TX_RESP;
                        byte_cnt_nxt = 3'd0;
                    end else begin
                        byte_cnt_nxt = 3'(byte_cnt + 3'd1);
                    end
                end
                ST_TX_RESP: begin
                    if (byte_cnt == resp_last) begin
                        state_nxt    = ST_WAIT_CMD;
                        byte_cnt_nxt = 3'd0;
                    end else begin
                        byte_cnt_nxt = 3'(byte_cnt + 3'd1);
                    end
                end
                default: begin
                    state_nxt    = ST_WAIT_CMD;
                    byte_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // CRC over bytes 1..5; restarted at every byte while hunting for a frame
    // start, since the first byte is only recognised once it is complete
    logic [6:0] crc7;
    logic       crc_clr;
    logic       crc_en;

    assign crc_clr = cs_act & rise & (state == ST_WAIT_CMD) & (bit_cnt == 3'd0);
    assign crc_en  = cs_act & rise &
                     ((state == ST_WAIT_CMD) || ((state == ST_RX_CMD) && (byte_cnt <= ARG_LAST)));

    sd_crc7 u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (mosi_s),
        .crc   (crc7)
    );

    // Capture index and argument of the frame in flight
    cmd_fields_t frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (byte_done_c) begin
            if ((state == ST_WAIT_CMD) && (rx_byte_c[7:6] == 2'b01)) begin
                frame.index <= rx_byte_c[5:0];
            end else if ((state == ST_RX_CMD) && (byte_cnt <= ARG_LAST)) begin
                frame.arg <= {frame.arg[23:0], rx_byte_c};
            end
        end
    end

    // Card flags
    logic              idle;
    logic              app_cmd;
    logic [POLL_W-1:0] polls_left;

    // Command decode; applied on the clock the crc byte completes
    logic              dec_idle;
    logic              dec_app;
    logic [POLL_W-1:0] dec_polls;
    logic              dec_spi;
    logic [RESP_W-1:0] dec_resp;
    logic [2:0]        dec_last;

    always_comb begin : decode
        logic        crc_ok;
        logic        illegal;
        logic        crc_err;
        logic        respond;
        logic        long_resp;
        logic [31:0] extra;
        logic [7:0]  r1;

        dec_idle  = idle;
        dec_app   = 1'b0;
        dec_polls = polls_left;
        dec_spi   = in_spi_mode;
        crc_ok    = (rx_byte_c == {crc7, 1'b1});
        illegal   = 1'b0;
        crc_err   = 1'b0;
        respond   = 1'b1;
        long_resp = 1'b0;
        extra     = 32'hFFFF_FFFF;
        r1        = 8'h00;

        // Until CMD0 is accepted the card stays silent to everything else
        if (!in_spi_mode && !((frame.index == CMD_GO_IDLE) && init_done)) begin
            respond = 1'b0;
        end else begin
            case (frame.index)
                CMD_GO_IDLE: begin
                    if (crc_ok) begin
                        dec_spi   = 1'b1;
                        dec_idle  = 1'b1;
                        dec_polls = POLL_W'(INIT_POLLS);
                    end else begin
                        crc_err = 1'b1;
                    end
                end
                CMD_SEND_IF_COND: begin
                    if (crc_ok) begin
                        long_resp = 1'b1;
                        extra     = {20'h00000, frame.arg[11:0]};
                    end else begin
                        crc_err = 1'b1;
                    end
                end
                CMD_APP_CMD: begin
                    dec_app = 1'b1;
                end
                ACMD_SEND_OP_COND: begin
                    if (!app_cmd) begin
                        illegal = 1'b1;
                    end else if (polls_left != '0) begin
                        dec_polls = POLL_W'(polls_left - 1'b1);
                    end else begin
                        dec_idle = 1'b0;
                    end
                end
                CMD_READ_OCR: begin
                    long_resp = 1'b1;
                    extra     = {~dec_idle, 1'(HIGH_CAPACITY), 6'b000000, OCR_VOLT_WINDOW};
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end

        r1[R1_IDLE_BIT]    = dec_idle;
        r1[R1_ILLEGAL_BIT] = illegal;
        r1[R1_CRC_ERR_BIT] = crc_err;
        dec_resp = respond ? {r1, extra} : {RESP_W{1'b1}};
        dec_last = (respond && long_resp) ? LAST_R3R7 : LAST_R1;
    end

    // Flags and command report outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle        <= 1'b1;
            app_cmd     <= 1'b0;
            polls_left  <= POLL_W'(INIT_POLLS);
            in_spi_mode <= 1'b0;
            card_ready  <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_index   <= 6'd0;
            cmd_arg     <= 32'd0;
        end else begin
            cmd_valid <= frame_done_c;
            if (frame_done_c) begin
                idle        <= dec_idle;
                app_cmd     <= dec_app;
                polls_left  <= dec_polls;
                in_spi_mode <= dec_spi;
                card_ready  <= dec_spi & ~dec_idle;
                cmd_index   <= frame.index;
                cmd_arg     <= frame.arg;
            end
        end
    end

    // Transmit path: next byte is loaded on the falling edge that opens it
    logic [7:0]        tx_shift;
    logic [RESP_W-1:0] resp_buf;
    logic              tx_load_c;
    logic [7:0]        tx_byte_c;

    assign tx_load_c = cs_act & fall & (bit_cnt == 3'd0);
    assign tx_byte_c = (state == ST_TX_RESP) ? resp_buf[RESP_W-1 -: 8] : FILL_BYTE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift  <= FILL_BYTE;
            miso      <= 1'b1;
            resp_buf  <= {RESP_W{1'b1}};
            resp_last <= LAST_R1;
        end else begin
            if (frame_done_c) begin
                resp_buf  <= dec_resp;
                resp_last <= dec_last;
            end
            if (!cs_act) begin
                tx_shift <= FILL_BYTE;
                miso     <= 1'b1;
            end else if (tx_load_c) begin
                tx_shift <= tx_byte_c;
                miso     <= tx_byte_c[7];
                if (state == ST_TX_RESP) begin
                    resp_buf <= {resp_buf[RESP_W-9:0], FILL_BYTE};
                end
            end else if (fall) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
                miso     <= tx_shift[6];
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: drives host SPI transactions and checks
// every miso byte and every cmd_valid report against queued expectations.
module tb_sd_spi_card_responder;

    localparam int NCR  = 1;
    localparam int HALF = 60;

    logic        clk;
    logic        rst_n;
    logic        spi_clk;
    logic        cs;
    logic        mosi;
    logic        miso;
    logic        in_spi_mode;
    logic        card_ready;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    int checks;
    int errors;

    logic [7:0]  miso_q[$];
    logic [37:0] cmd_q[$];

    sd_spi_card_responder #(
        .NCR           (NCR),
        .INIT_POLLS    (2),
        .HIGH_CAPACITY (1),
        .MIN_INIT_CLKS (74)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .in_spi_mode (in_spi_mode),
        .card_ready  (card_ready),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Miso monitor: assembles bytes on host sampling edges
    initial begin : miso_mon
        int         nbits;
        int         nbyte;
        logic [7:0] sh;
        logic [7:0] e;
        nbits = 0;
        nbyte = 0;
        sh    = 8'h00;
        forever begin
            @(posedge spi_clk or posedge cs);
            if (cs) begin
                nbits = 0;
            end else begin
                sh = {sh[6:0], miso};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (miso_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL miso byte %0d: got 0x%02h expected none", nbyte, sh);
                    end else begin
                        e = miso_q.pop_front();
                        check($sformatf("miso byte %0d", nbyte), 64'(sh), 64'(e));
                    end
                    nbyte++;
                end
            end
        end
    end

    // Command report monitor
    initial begin : cmd_mon
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_valid: got pulse index %0d expected none", cmd_index);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_index", 64'(cmd_index), 64'(e[37:32]));
                    check("cmd_arg", 64'(cmd_arg), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #(HALF);
            spi_clk = 1'b1;
            #(HALF);
            spi_clk = 1'b0;
        end
        mosi = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] exp);
        miso_q.push_back(exp);
        spi_byte(b);
    endtask

    task automatic cs_set(input logic v);
        cs = v;
        #200;
    endtask

    task automatic idle_clocks(input int n);
        cs_set(1'b1);
        repeat (n) begin
            #(HALF);
            spi_clk = 1'b1;
            #(HALF);
            spi_clk = 1'b0;
        end
        #200;
    endtask

    // Frame plus NCR+5 filler bytes; resp is left-justified, n bytes long
    task automatic do_cmd(input logic [7:0] b0, input logic [31:0] arg, input logic [7:0] crc,
                          input int n, input logic [39:0] resp);
        logic [47:0] fr;
        logic [39:0] r;
        fr = {b0, arg, crc};
        r  = resp;
        cmd_q.push_back({b0[5:0], arg});
        for (int k = 0; k < 6; k++) begin
            xfer(fr[47:40], 8'hFF);
            fr = fr << 8;
        end
        for (int k = 0; k < NCR + 5; k++) begin
            if (k < NCR || k >= NCR + n) begin
                xfer(8'hFF, 8'hFF);
            end else begin
                xfer(8'hFF, r[39:32]);
                r = r << 8;
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        spi_clk = 1'b0;
        cs      = 1'b1;
        mosi    = 1'b1;
        #100;
        check("rst miso", 64'(miso), 64'd1);
        check("rst in_spi_mode", 64'(in_spi_mode), 64'd0);
        check("rst card_ready", 64'(card_ready), 64'd0);
        check("rst cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst cmd_index", 64'(cmd_index), 64'd0);
        check("rst cmd_arg", 64'(cmd_arg), 64'd0);
        rst_n = 1'b1;
        #100;

        // Too few init clocks: CMD0 ignored
        idle_clocks(40);
        cs_set(1'b0);
        do_cmd(8'h40, 32'h0, 8'h95, 0, 40'h0);
        cs_set(1'b1);
        check("early cmd0 in_spi_mode", 64'(in_spi_mode), 64'd0);

        // Enough clocks: CMD0 accepted
        idle_clocks(80);
        cs_set(1'b0);
        do_cmd(8'h40, 32'h0, 8'h95, 1, 40'h01_00000000);
        check("cmd0 in_spi_mode", 64'(in_spi_mode), 64'd1);
        check("cmd0 card_ready", 64'(card_ready), 64'd0);

        // CMD8 good and bad CRC
        do_cmd(8'h48, 32'h000001AA, 8'h87, 5, 40'h01_000001AA);
        do_cmd(8'h48, 32'h000001AA, 8'h01, 1, 40'h09_00000000);

        // Illegal commands
        do_cmd(8'h51, 32'h0, 8'h01, 1, 40'h05_00000000);
        do_cmd(8'h69, 32'h40000000, 8'h01, 1, 40'h05_00000000);

        // ACMD41 polling until ready
        for (int p = 0; p < 3; p++) begin
            do_cmd(8'h77, 32'h0, 8'h01, 1, 40'h01_00000000);
            do_cmd(8'h69, 32'h40000000, 8'h01, 1, (p < 2) ? 40'h01_00000000 : 40'h00_00000000);
        end
        check("acmd41 card_ready", 64'(card_ready), 64'd1);
        do_cmd(8'h7A, 32'h0, 8'h01, 5, 40'h00_C0FF8000);

        // Bad-CRC CMD0 once ready: flags untouched
        do_cmd(8'h40, 32'h0, 8'h01, 1, 40'h08_00000000);
        check("bad cmd0 card_ready", 64'(card_ready), 64'd1);

        // Aborted frame, then a full CMD0
        xfer(8'h40, 8'hFF);
        xfer(8'h00, 8'hFF);
        xfer(8'h00, 8'hFF);
        cs_set(1'b1);
        check("abort miso", 64'(miso), 64'd1);
        cs_set(1'b0);
        do_cmd(8'h40, 32'h0, 8'h95, 1, 40'h01_00000000);
        check("recmd0 card_ready", 64'(card_ready), 64'd0);
        check("recmd0 in_spi_mode", 64'(in_spi_mode), 64'd1);

        // Reset in the middle of an R1 byte
        cmd_q.push_back({6'd0, 32'd0});
        for (int k = 0; k < 6; k++) begin
            xfer((k == 0) ? 8'h40 : ((k == 5) ? 8'h95 : 8'h00), 8'hFF);
        end
        xfer(8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            #(HALF);
            spi_clk = 1'b1;
            #(HALF);
            spi_clk = 1'b0;
        end
        #100;
        check("mid r1 miso", 64'(miso), 64'd0);
        rst_n = 1'b0;
        #1;
        check("reset miso", 64'(miso), 64'd1);
        check("reset in_spi_mode", 64'(in_spi_mode), 64'd0);
        #9;
        cs_set(1'b1);
        rst_n = 1'b1;
        #1000;

        check("miso queue drained", 64'(miso_q.size()), 64'd0);
        check("cmd queue drained", 64'(cmd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
